// File: rtl/gmii_tx_framer.sv
// gmii_tx_framer: turns a valid/ready/last byte stream into GMII transmit
// frames (preamble, SFD, payload, optional pad, CRC-32 FCS, inter-frame gap).
// An underrun or oversize payload ends the frame with one tx_er_o byte and an
// abort_o pulse, and the rest of the payload is then drained until last_i.
// Optional feature: define GMII_TX_FRAMER_PAD_EN to zero-pad short frames to
// 60 payload bytes, with the pad bytes included in the CRC.
module gmii_tx_framer #(
    parameter int ifg_cycles_p  = 12,
    parameter int max_payload_p = 1514
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    input  logic       last_i,
    output logic       ready_o,
    output logic [7:0] txd_o,
    output logic       tx_en_o,
    output logic       tx_er_o,
    output logic       done_o,
    output logic       abort_o
);

    localparam logic [10:0] MaxPayload = 11'(max_payload_p);
    localparam logic [7:0]  IfgLast    = 8'(ifg_cycles_p - 1);
    localparam logic [31:0] CrcPoly    = 32'hEDB88320;
    localparam logic [31:0] CrcSeed    = 32'hFFFFFFFF;
`ifdef GMII_TX_FRAMER_PAD_EN
    localparam logic [10:0] MinPayload = 11'd60;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_SFD,
        ST_DATA,
`ifdef GMII_TX_FRAMER_PAD_EN
        ST_PAD,
`endif
        ST_FCS,
        ST_DRAIN,
        ST_IFG
    } state_t;

    state_t      r_state;
    logic [7:0]  r_txd;
    logic        r_tx_en;
    logic        r_tx_er;
    logic        r_done;
    logic        r_abort;
    logic [31:0] r_crc;
    logic [10:0] r_cnt;
    logic [2:0]  r_pre_cnt;
    logic [1:0]  r_fcs_cnt;
    logic [7:0]  r_ifg_cnt;

    logic        w_ready;
    logic        w_accept;
    logic        w_cnt_full;
    logic [10:0] w_cnt_inc;
    logic [7:0]  w_crc_byte;
    logic [31:0] w_crc_next;
    logic [31:0] w_fcs;
    logic [7:0]  w_fcs_byte;

    // One byte of the reflected CRC-32, LSB of the data byte first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                               input logic [7:0]  data);
        logic [31:0] c;
        c = crc;
        for (int b = 0; b < 8; b++) begin
            c = {1'b0, c[31:1]} ^ ((c[0] ^ data[b]) ? CrcPoly : 32'h0);
        end
        return c;
    endfunction

    // The counter saturates; once it has reached the maximum payload the block
    // stops accepting in DATA so the oversize abort fires on the next cycle.
    assign w_cnt_full = (r_cnt >= MaxPayload);
    assign w_ready    = ((r_state == ST_DATA) && !w_cnt_full) || (r_state == ST_DRAIN);
    assign w_accept   = valid_i && w_ready;
    assign w_cnt_inc  = (r_cnt == 11'h7FF) ? r_cnt : (r_cnt + 11'd1);
    assign w_crc_byte = (r_state == ST_DATA) ? data_i : 8'h00;
    assign w_crc_next = crc32_byte(r_crc, w_crc_byte);
    assign w_fcs      = ~r_crc;

    // Select the FCS byte to send, least-significant byte first.
    always_comb begin
        w_fcs_byte = w_fcs[7:0];
        case (r_fcs_cnt)
            2'd0:    w_fcs_byte = w_fcs[7:0];
            2'd1:    w_fcs_byte = w_fcs[15:8];
            2'd2:    w_fcs_byte = w_fcs[23:16];
            default: w_fcs_byte = w_fcs[31:24];
        endcase
    end

    // Framing state machine with registered GMII outputs and status pulses.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state   <= ST_IDLE;
            r_txd     <= 8'h00;
            r_tx_en   <= 1'b0;
            r_tx_er   <= 1'b0;
            r_done    <= 1'b0;
            r_abort   <= 1'b0;
            r_crc     <= CrcSeed;
            r_cnt     <= 11'd0;
            r_pre_cnt <= 3'd0;
            r_fcs_cnt <= 2'd0;
            r_ifg_cnt <= 8'd0;
        end else begin
            r_txd   <= 8'h00;
            r_tx_en <= 1'b0;
            r_tx_er <= 1'b0;
            r_done  <= 1'b0;
            r_abort <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_crc <= CrcSeed;
                    r_cnt <= 11'd0;
                    // The waiting byte only starts the preamble; it is taken later in DATA.
                    if (valid_i) begin
                        r_txd     <= 8'h55;
                        r_tx_en   <= 1'b1;
                        r_pre_cnt <= 3'd1;
                        r_state   <= ST_PREAMBLE;
                    end
                end
                ST_PREAMBLE: begin
                    r_txd     <= 8'h55;
                    r_tx_en   <= 1'b1;
                    r_pre_cnt <= r_pre_cnt + 3'd1;
                    if (r_pre_cnt == 3'd6) begin
                        r_state <= ST_SFD;
                    end
                end
                ST_SFD: begin
                    r_txd   <= 8'hD5;
                    r_tx_en <= 1'b1;
                    r_state <= ST_DATA;
                end
                ST_DATA: begin
                    if (w_accept) begin
                        r_txd   <= data_i;
                        r_tx_en <= 1'b1;
                        r_crc   <= w_crc_next;
                        r_cnt   <= w_cnt_inc;
                        if (last_i) begin
                            r_fcs_cnt <= 2'd0;
`ifdef GMII_TX_FRAMER_PAD_EN
                            if (w_cnt_inc < MinPayload) begin
                                r_state <= ST_PAD;
                            end else begin
                                r_state <= ST_FCS;
                            end
`else
                            r_state <= ST_FCS;
`endif
                        end
                    end else begin
                        // Underrun, or payload already at its maximum without last_i.
                        r_txd   <= 8'h00;
                        r_tx_en <= 1'b1;
                        r_tx_er <= 1'b1;
                        r_abort <= 1'b1;
                        r_state <= ST_DRAIN;
                    end
                end
`ifdef GMII_TX_FRAMER_PAD_EN
                ST_PAD: begin
                    r_txd   <= 8'h00;
                    r_tx_en <= 1'b1;
                    r_crc   <= w_crc_next;
                    r_cnt   <= w_cnt_inc;
                    if (w_cnt_inc >= MinPayload) begin
                        r_state <= ST_FCS;
                    end
                end
`endif
                ST_FCS: begin
                    r_txd     <= w_fcs_byte;
                    r_tx_en   <= 1'b1;
                    r_fcs_cnt <= r_fcs_cnt + 2'd1;
                    if (r_fcs_cnt == 2'd3) begin
                        r_done    <= 1'b1;
                        r_ifg_cnt <= 8'd0;
                        r_state   <= ST_IFG;
                    end
                end
                ST_DRAIN: begin
                    if (w_accept && last_i) begin
                        r_ifg_cnt <= 8'd0;
                        r_state   <= ST_IFG;
                    end
                end
                ST_IFG: begin
                    // The cycle carrying the last FCS byte is the first IFG cycle,
                    // and the IDLE cycle that follows completes the idle gap.
                    if (r_ifg_cnt >= IfgLast) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_ifg_cnt <= r_ifg_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready_o = w_ready;
    assign txd_o   = r_txd;
    assign tx_en_o = r_tx_en;
    assign tx_er_o = r_tx_er;
    assign done_o  = r_done;
    assign abort_o = r_abort;

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Testbench for gmii_tx_framer: randomized frames, a table-driven CRC-32
// reference model and a frame-level scoreboard fed at stimulus time.
module tb_gmii_tx_framer;

    localparam int IFG      = 12;
    localparam int MAXP     = 1514;
    localparam int WAIT_MAX = 4000;

    logic       clk_i = 1'b0;
    logic       reset_n_i = 1'b1;
    logic [7:0] data_i = 8'h00;
    logic       valid_i = 1'b0;
    logic       last_i = 1'b0;
    logic       ready_o;
    logic [7:0] txd_o;
    logic       tx_en_o;
    logic       tx_er_o;
    logic       done_o;
    logic       abort_o;

    gmii_tx_framer #(
        .ifg_cycles_p (IFG),
        .max_payload_p(MAXP)
    ) dut (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .data_i   (data_i),
        .valid_i  (valid_i),
        .last_i   (last_i),
        .ready_o  (ready_o),
        .txd_o    (txd_o),
        .tx_en_o  (tx_en_o),
        .tx_er_o  (tx_er_o),
        .done_o   (done_o),
        .abort_o  (abort_o)
    );

    always #5 clk_i = ~clk_i;

    typedef logic [7:0] bq_t[$];

    // Expected bytes are {done, abort, er, txd}; one length and one gap per frame.
    logic [10:0] exp_q[$];
    int          exp_len_q[$];
    int          exp_gap_q[$];

    int          checks = 0;
    int          errors = 0;
    int          stray = 0;
    int          frame_no = 0;
    logic [31:0] crc_tab[256];
    bit          have_prev = 1'b0;
    bit          prev_clean = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Reference CRC-32 (IEEE 802.3), byte-table form, returns the value to send.
    function automatic logic [31:0] crc_model(input bq_t b);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (b[i]) c = crc_tab[(c[7:0] ^ b[i])] ^ (c >> 8);
        return ~c;
    endfunction

    // Frame image from the rules: 7x55, D5, payload(+pad), FCS LSB first; or,
    // for an abort, the bytes sent before the fault followed by one error byte.
    task automatic push_expected(input bq_t pl, input int cut, input int gap_kind);
        bq_t         body;
        logic [31:0] crc;
        int          n;
        exp_gap_q.push_back(gap_kind);
        for (int i = 0; i < 7; i++) exp_q.push_back({3'b000, 8'h55});
        exp_q.push_back({3'b000, 8'hD5});
        n = 8;
        if (cut < 0) begin
            body = pl;
`ifdef GMII_TX_FRAMER_PAD_EN
            while (body.size() < 60) body.push_back(8'h00);
`endif
            crc = crc_model(body);
            foreach (body[i]) exp_q.push_back({3'b000, body[i]});
            for (int k = 0; k < 4; k++) exp_q.push_back({(k == 3), 2'b00, crc[8*k +: 8]});
            n += body.size() + 4;
        end else begin
            for (int i = 0; i < cut; i++) exp_q.push_back({3'b000, pl[i]});
            exp_q.push_back({3'b011, 8'h00});
            n += cut + 1;
        end
        exp_len_q.push_back(n);
    endtask

    task automatic drive_byte(input logic [7:0] d, input logic l);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        data_i = d;
        last_i = l;
        valid_i = 1'b1;
        while (!acc && n < WAIT_MAX) begin
            @(negedge clk_i);
            acc = ready_o;
            @(posedge clk_i);
            #1;
            n++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout: ready_o stayed 0 for %0d cycles, required 1", n);
        end
    endtask

    function automatic int gap_kind_now(input int delay);
        if (!have_prev) return -1;
        if (delay == 0 && prev_clean) return IFG;
        return 0;
    endfunction

    // cut < 0: normal frame; cut > 0: valid_i drops after cut accepted bytes
    // (or, for cut == MAXP, the payload simply runs past the maximum).
    task automatic send_frame(input bq_t pl, input int cut, input int delay);
        valid_i = 1'b0;
        last_i = 1'b0;
        repeat (delay) begin
            @(posedge clk_i);
            #1;
        end
        push_expected(pl, cut, gap_kind_now(delay));
        for (int i = 0; i < pl.size(); i++) begin
            drive_byte(pl[i], (i == pl.size() - 1));
            if (cut > 0 && cut < MAXP && i == cut - 1) begin
                valid_i = 1'b0;
                repeat (1 + int'($urandom % 3)) begin
                    @(posedge clk_i);
                    #1;
                end
            end else if (cut > 0 && i >= cut && ($urandom % 2) == 0) begin
                valid_i = 1'b0;
                @(posedge clk_i);
                #1;
            end
        end
        valid_i = 1'b0;
        last_i = 1'b0;
        have_prev = 1'b1;
        prev_clean = (cut < 0);
    endtask

    function automatic bq_t rand_payload(input int len);
        bq_t p;
        for (int i = 0; i < len; i++) p.push_back(8'($urandom));
        return p;
    endfunction

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_txd"}, {24'h0, txd_o}, 32'h0);
        chk({tag, "_tx_en"}, {31'h0, tx_en_o}, 32'h0);
        chk({tag, "_tx_er"}, {31'h0, tx_er_o}, 32'h0);
        chk({tag, "_ready"}, {31'h0, ready_o}, 32'h0);
        chk({tag, "_done"}, {31'h0, done_o}, 32'h0);
        chk({tag, "_abort"}, {31'h0, abort_o}, 32'h0);
    endtask

    // Monitor: gathers each tx_en_o burst and compares it with the scoreboard.
    initial begin
        logic [10:0] cap[$];
        bit          in_frame;
        int          idle_cnt;
        in_frame = 1'b0;
        idle_cnt = 0;
        forever begin
            @(negedge clk_i);
            if (!reset_n_i) begin
                in_frame = 1'b0;
                cap.delete();
                idle_cnt = 0;
            end else if (tx_en_o) begin
                if (!in_frame) begin
                    in_frame = 1'b1;
                    if (exp_gap_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame_start: got tx_en_o=1, required no frame");
                    end else begin
                        int g;
                        g = exp_gap_q.pop_front();
                        if (g == IFG) begin
                            chk("ifg_gap_exact", idle_cnt, IFG);
                        end else if (g == 0) begin
                            checks++;
                            if (idle_cnt < IFG) begin
                                errors++;
                                $display("FAIL ifg_gap_min: got %0d idle cycles, required >= %0d", idle_cnt, IFG);
                            end
                        end
                    end
                end
                cap.push_back({done_o, abort_o, tx_er_o, txd_o});
            end else begin
                if (in_frame) begin
                    in_frame = 1'b0;
                    frame_no++;
                    if (exp_len_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame: got %0d bytes, required none", cap.size());
                    end else begin
                        int len;
                        int nbad;
                        len = exp_len_q.pop_front();
                        nbad = 0;
                        chk("frame_len", cap.size(), len);
                        for (int i = 0; i < len; i++) begin
                            logic [10:0] e;
                            e = exp_q.pop_front();
                            if (i < cap.size()) begin
                                checks++;
                                if (cap[i] !== e) begin
                                    errors++;
                                    if (nbad < 4)
                                        $display("FAIL frame_byte[%0d]: got {done,abort,er,txd}=%03h, required %03h", i, cap[i], e);
                                    nbad++;
                                end
                            end
                        end
                        $display("frame %0d: %0d bytes on tx_en_o, %0d byte differences", frame_no, cap.size(), nbad);
                    end
                    cap.delete();
                    idle_cnt = 0;
                end
                idle_cnt++;
                if (done_o || abort_o || tx_er_o || (txd_o != 8'h00)) stray++;
            end
        end
    end

    // Stimulus
    initial begin
        bq_t pl;
        int  n;
        for (int i = 0; i < 256; i++) begin
            logic [31:0] c;
            c = 32'(i);
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            crc_tab[i] = c;
        end

        #1 reset_n_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        check_outputs_zero("reset");
        reset_n_i = 1'b1;
        @(posedge clk_i);
        #1;

        // 64-byte counting payload
        pl.delete();
        for (int i = 0; i < 64; i++) pl.push_back(8'(i));
        send_frame(pl, -1, 3);
        $display("sent 64-byte counting frame");

        // Short frame, then a back-to-back pair
        send_frame(rand_payload(10), -1, 5);
        send_frame(rand_payload(20), -1, 0);
        send_frame(rand_payload(30), -1, 0);

        // Underrun after 20 bytes of 40
        send_frame(rand_payload(40), 20, 4);

        // Reset during payload byte 30: frame truncated, no expectation pushed
        exp_gap_q.push_back(gap_kind_now(2));
        repeat (2) begin
            @(posedge clk_i);
            #1;
        end
        pl = rand_payload(50);
        for (int i = 0; i < 30; i++) drive_byte(pl[i], 1'b0);
        data_i = pl[30];
        #2 reset_n_i = 1'b0;
        #1;
        check_outputs_zero("midframe_reset");
        valid_i = 1'b0;
        repeat (3) @(negedge clk_i);
        reset_n_i = 1'b1;
        have_prev = 1'b0;
        $display("reset applied during payload byte 30");
        send_frame(rand_payload(45), -1, 2);

        // Pad boundaries and single-byte frame
        send_frame(rand_payload(1), -1, 1);
        send_frame(rand_payload(59), -1, 0);
        send_frame(rand_payload(60), -1, 0);
        send_frame(rand_payload(61), -1, 3);

        // Maximum payload exactly, then oversize
        send_frame(rand_payload(MAXP), -1, 0);
        send_frame(rand_payload(MAXP + 6), MAXP, 2);

        // Randomized traffic
        for (int f = 0; f < 20; f++) begin
            int len;
            int cut;
            int delay;
            len = 1 + int'($urandom % 120);
            cut = (len >= 2 && ($urandom % 4) == 0) ? 1 + int'($urandom % (len - 1)) : -1;
            delay = (($urandom % 3) == 0) ? 0 : int'($urandom % 15);
            send_frame(rand_payload(len), cut, delay);
        end

        n = 0;
        while (exp_len_q.size() > 0 && n < 5000) begin
            @(posedge clk_i);
            n++;
        end
        if (exp_len_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL frames_outstanding: got %0d frames missing, required 0", exp_len_q.size());
        end
        repeat (30) @(posedge clk_i);
        chk("stray_outputs_while_idle", stray, 0);
        chk("unused_gap_entries", exp_gap_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
